store_sub_word_unit: RTL and testbench
======================================

// Module: store_sub_word_unit
// PURPOSE
// - Write-side counterpart of the load slicer (getByteOrHw): performs sw/sh/sb to the word-wide Memoria.
// - Sub-word stores use read-modify-write: read aligned word, merge byte/halfword lane, write back.
// - Sits between controlador (start/done handshake) and the Memoria Address/Wr/DataIn mux inputs.
// - Source data is B register; byte address is AluOut.
// PARAMETERS
// - READ_WAIT  1  cycles Memoria needs between address presentation and valid DataOut (>=1)
// PORTS
// - Clk        in   1   system clock
// - Reset      in   1   synchronous, active-high reset
// - start      in   1   one-cycle request from controlador; sampled only in IDLE
// - size       in   2   00 word, 01 halfword, 10 byte, 11 illegal
// - addr       in   32  byte address of the store
// - wdata      in   32  store data; byte uses [7:0], halfword uses [15:0]
// - mem_rdata  in   32  Memoria DataOut
// - mem_addr   out  32  word-aligned address to Memoria: {addr_q[31:2],2'b00}
// - mem_wr     out  1   Memoria write enable
// - mem_wdata  out  32  merged word to Memoria DataIn
// - busy       out  1   high in every state except IDLE
// - done       out  1   one-cycle pulse at completion
// - misaligned out  1   valid with done: store not performed (exception request)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; latched addr/size/wdata/merge regs cleared.
// - Clock and reset are fixed: one clock (Clk); Reset is synchronous, active-high.
// - In IDLE with start=1: latch addr, size, wdata; choose next state:
//   - size=00: WR.
//   - size=01 with addr[0]=0, or size=10: RD.
//   - size=11, or size=01 with addr[0]=1: FAULT.
// - RD: mem_addr driven, mem_wr=0; a wait counter counts READ_WAIT cycles, then CAP.
// - CAP: capture mem_rdata into merge register, replacing the lane:
//   - byte: lane k=addr_q[1:0] gets bits [8k+7:8k]=wdata_q[7:0].
//   - halfword: addr_q[1]=0 -> [15:0], addr_q[1]=1 -> [31:16] get wdata_q[15:0].
//   - Other bits keep their read values (little-endian lane order).
// - WR: mem_wr=1 for exactly one cycle.
//   - mem_wdata = wdata_q for word stores, merge register otherwise.
//   - Next state: DONE.
// - DONE: done=1, misaligned=0; next IDLE.
// - FAULT: done=1, misaligned=1; mem_wr never asserted; next IDLE.
// - mem_addr: 0 in IDLE, aligned latched address in all other states.
// - mem_wdata: 0 outside WR.
// - Latency from the start cycle to the done pulse:
//   - word: 2 cycles.
//   - sub-word: READ_WAIT+3 cycles.
//   - fault: 1 cycle.
// - Word store ignores addr_q[1:0], matching sw.
// - start while busy: ignored; no queuing.
// - New start in the same cycle as done: ignored, since state is not yet IDLE.
// - Reset mid-operation (any state): IDLE next edge; mem_wr=0 after that edge.
//   A pending write is dropped; no partial write occurs.
// - Inputs addr/size/wdata may change after start without effect.
// TESTING
// - Word: start, size=00, addr=0x0000_0010, wdata=0xDEADBEEF.
//   -> mem_wr=1 in cycle 1 with mem_addr=0x10, mem_wdata=0xDEADBEEF; done in cycle 2.
// - Byte: mem[0x20]=0x11223344; sb addr=0x22 wdata=0xFFFF_FFAB.
//   -> RD, then write 0x11AB3344 to 0x20; done at cycle READ_WAIT+3.
// - Halfword: mem[0x20]=0x11223344; sh addr=0x22 wdata=0x0000_BEEF -> write 0xBEEF3344.
//   Repeat with addr=0x20 -> 0x1122BEEF.
// - Fault: sh addr=0x21 -> done and misaligned in cycle 1; mem_wr never 1; memory unchanged.
//   size=11 behaves the same.
// - Busy/reset: start again during RD -> ignored, one write only.
//   Reset asserted in CAP -> no mem_wr, outputs 0, IDLE.
// - Sweep: all 4 byte lanes and both halfword lanes with random data;
//   memory model compare after every done.

Source files
------------

// File: rtl/store_sub_word_unit.sv
// store_sub_word_unit: performs sw/sh/sb to a word-wide memory.
// Word stores write directly. Halfword and byte stores do a read-modify-write
// of the aligned word. Misaligned or illegal sizes return done with misaligned set.
module store_sub_word_unit #(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam int unsigned CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t           state;
  logic [1:0]       addrQ;     // byte offset within the word selects the lane
  logic [1:0]       sizeQ;
  logic [15:0]      wdataQ;    // only the low halfword is ever merged
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      mergedWord;

  // Replace the addressed byte/halfword lane of the read word, little-endian order
  always_comb begin
    mergedWord = mem_rdata;
    if (sizeQ == SZ_BYTE) begin
      case (addrQ)
        2'd0:    mergedWord[7:0]   = wdataQ[7:0];
        2'd1:    mergedWord[15:8]  = wdataQ[7:0];
        2'd2:    mergedWord[23:16] = wdataQ[7:0];
        default: mergedWord[31:24] = wdataQ[7:0];
      endcase
    end else if (addrQ[1]) begin
      mergedWord[31:16] = wdataQ;
    end else begin
      mergedWord[15:0] = wdataQ;
    end
  end

  // Control FSM; outputs are registered from the state being entered.
  // mem_wdata is loaded with the final (merged) word on entry to WR.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      addrQ      <= 2'b00;
      sizeQ      <= 2'b00;
      wdataQ     <= 16'h0000;
      waitCnt    <= '0;
      mem_addr   <= 32'h0000_0000;
      mem_wr     <= 1'b0;
      mem_wdata  <= 32'h0000_0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      mem_wr     <= 1'b0;
      mem_wdata  <= 32'h0000_0000;
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addrQ    <= addr[1:0];
            sizeQ    <= size;
            wdataQ   <= wdata[15:0];
            waitCnt  <= '0;
            busy     <= 1'b1;
            mem_addr <= {addr[31:2], 2'b00};
            if (size == SZ_WORD) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_wdata <= wdata;
            end else if ((size == SZ_HALF && !addr[0]) || size == SZ_BYTE) begin
              state <= RD;
            end else begin
              state      <= FAULT;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end
          end
        end
        RD: begin
          if (waitCnt == WAIT_LAST) begin
            state <= CAP;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        CAP: begin
          state     <= WR;
          mem_wr    <= 1'b1;
          mem_wdata <= mergedWord;
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, FAULT: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= 32'h0000_0000;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_sub_word_unit.sv
// Directed bench for store_sub_word_unit with a one-cycle-latency memory model.
module tb_store_sub_word_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] memRdata;
  logic [31:0] memAddr;
  logic        memWr;
  logic [31:0] memWdata;
  logic        busy;
  logic        done;
  logic        misaligned;

  int tests = 0;
  int failed = 0;

  logic [31:0] mem [0:255];
  int          wrCount = 0;
  logic [31:0] lastWrAddr = 32'h0;
  logic        pokeEn = 1'b0;
  logic [7:0]  pokeIdx = 8'h0;
  logic [31:0] pokeData = 32'h0;

  store_sub_word_unit #(.READ_WAIT(1)) dut (
    .Clk(clk), .Reset(rst), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(memRdata), .mem_addr(memAddr), .mem_wr(memWr),
    .mem_wdata(memWdata), .busy(busy), .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Memory: registered read (READ_WAIT=1), write on mem_wr, bench preload port
  always @(posedge clk) begin
    if (pokeEn) mem[pokeIdx] <= pokeData;
    if (memWr) begin
      mem[memAddr[9:2]] <= memWdata;
      wrCount           <= wrCount + 1;
      lastWrAddr        <= memAddr;
    end
    memRdata <= mem[memAddr[9:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    pokeIdx  = idx;
    pokeData = data;
    pokeEn   = 1'b1;
    step();
    pokeEn   = 1'b0;
  endtask

  // One store from IDLE; checks latency, misaligned, write count/address and final word
  task automatic runStore(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int expLat, input logic expMis,
                          input logic [31:0] expWord, input logic hold);
    int lat;
    int wr0;
    wr0   = wrCount;
    lat   = 0;
    size  = sz;
    addr  = a;
    wdata = d;
    start = 1'b1;
    do begin
      step();
      lat++;
      if (!(hold && lat == 1)) start = 1'b0;
      addr  = $urandom;
      wdata = $urandom;
      size  = 2'(lat);
    end while (!done && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'(expLat));
    check({tag, "_misaligned"}, {31'b0, misaligned}, {31'b0, expMis});
    check({tag, "_writes"}, 32'(wrCount - wr0), expMis ? 32'd0 : 32'd1);
    if (!expMis) check({tag, "_wraddr"}, lastWrAddr, {a[31:2], 2'b00});
    check({tag, "_mem"}, mem[a[9:2]], expWord);
    if (hold) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] msk;
    int          sh;
    int          wr0;

    rst   = 1'b1;
    start = 1'b0;
    size  = 2'b00;
    addr  = 32'h0;
    wdata = 32'h0;
    step();
    step();
    check("reset_addr", memAddr, 32'h0);
    check("reset_wdata", memWdata, 32'h0);
    check("reset_flags", {28'b0, memWr, busy, done, misaligned}, 32'h0);
    rst = 1'b0;

    // Word store, cycle-by-cycle
    start = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'hDEADBEEF;
    step();
    start = 1'b0; addr = 32'h3FC; wdata = 32'h0; size = 2'b11;
    check("word_c1_wr", {31'b0, memWr}, 32'd1);
    check("word_c1_addr", memAddr, 32'h10);
    check("word_c1_wdata", memWdata, 32'hDEADBEEF);
    check("word_c1_busy_done", {30'b0, busy, done}, 32'd2);
    step();
    check("word_c2_done", {29'b0, done, misaligned, memWr}, 32'd4);
    check("word_c2_wdata", memWdata, 32'h0);
    check("word_mem", mem[4], 32'hDEADBEEF);
    step();
    check("word_idle", {31'b0, busy}, 32'd0);
    check("word_idle_addr", memAddr, 32'h0);

    // Word store ignores the low address bits
    runStore("word_unaligned", 2'b00, 32'h33, 32'h01234567, 2, 1'b0, 32'h01234567, 1'b0);

    // Byte and halfword read-modify-write
    poke(8'd8, 32'h11223344);
    runStore("sb_22", 2'b10, 32'h22, 32'hFFFFFFAB, 4, 1'b0, 32'h11AB3344, 1'b0);
    poke(8'd8, 32'h11223344);
    runStore("sh_22", 2'b01, 32'h22, 32'h0000BEEF, 4, 1'b0, 32'hBEEF3344, 1'b0);
    poke(8'd8, 32'h11223344);
    runStore("sh_20", 2'b01, 32'h20, 32'h0000BEEF, 4, 1'b0, 32'h1122BEEF, 1'b0);

    // Faults: misaligned halfword and illegal size leave memory untouched
    runStore("sh_21_fault", 2'b01, 32'h21, 32'h0000BEEF, 1, 1'b1, 32'h1122BEEF, 1'b0);
    poke(8'd9, 32'hA5A5A5A5);
    runStore("size11_fault", 2'b11, 32'h24, 32'h12345678, 1, 1'b1, 32'hA5A5A5A5, 1'b0);

    // start held during RD and re-raised with done: exactly one write, no restart
    poke(8'd10, 32'h00000000);
    runStore("busy_restart", 2'b10, 32'h29, 32'h000000C3, 4, 1'b0, 32'h0000C300, 1'b1);

    // Reset while in CAP drops the write
    poke(8'd11, 32'hCAFEF00D);
    wr0 = wrCount;
    start = 1'b1; size = 2'b10; addr = 32'h2F; wdata = 32'h55;
    step();
    start = 1'b0;
    check("rst_rd_addr", memAddr, 32'h2C);
    check("rst_rd_wr", {31'b0, memWr}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("rst_cap_flags", {28'b0, memWr, busy, done, misaligned}, 32'h0);
    check("rst_cap_addr", memAddr, 32'h0);
    check("rst_cap_wdata", memWdata, 32'h0);
    rst = 1'b0;
    step();
    check("rst_cap_writes", 32'(wrCount - wr0), 32'd0);
    check("rst_cap_mem", mem[11], 32'hCAFEF00D);
    check("rst_cap_idle", {31'b0, busy}, 32'd0);

    // Sweep every byte lane and both halfword lanes with random data
    for (int i = 0; i < 6; i++) begin
      old = $urandom;
      d   = $urandom;
      poke(8'(16 + i), old);
      if (i < 4) begin
        sh  = 8 * i;
        msk = 32'h0000_00FF;
        a   = 32'((16 + i) * 4 + i);
        runStore($sformatf("sweep_sb%0d", i), 2'b10, a, d, 4, 1'b0,
                 (old & ~(msk << sh)) | ((d & msk) << sh), 1'b0);
      end else begin
        sh  = 16 * (i - 4);
        msk = 32'h0000_FFFF;
        a   = 32'((16 + i) * 4 + 2 * (i - 4));
        runStore($sformatf("sweep_sh%0d", i - 4), 2'b01, a, d, 4, 1'b0,
                 (old & ~(msk << sh)) | ((d & msk) << sh), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
